// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB full-speed receive path
// (bit recovery, shift register and RCU).
package usb_rx_pkg;
    localparam int   CLKS_PER_BIT = 8;
    localparam int   SAMPLE_POINT = 3;
    localparam int   STUFF_LEN    = 6;
    localparam logic IDLE_LEVEL   = 1'b1;
    localparam int   CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int   ONES_W = $clog2(STUFF_LEN + 1);
endpackage

// File: rtl/rx_bit_recover_if.sv
// Line-side inputs and shift-register/RCU outputs
// of the bit-recovery stage.
interface rx_bit_recover_if;
    logic d_plus_sync;
    logic d_edge;
    logic enable;
    logic shift_enable;
    logic rx_bit;
    logic byte_received;
    logic stuff_error;

    modport master (
        output d_plus_sync, d_edge, enable,
        input  shift_enable, rx_bit, byte_received, stuff_error
    );

    modport slave (
        input  d_plus_sync, d_edge, enable,
        output shift_enable, rx_bit, byte_received, stuff_error
    );
endinterface

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and
// programmable rollover value.
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         count_enable,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
endmodule

// File: rtl/rx_bit_recover.sv
// USB FS bit recovery: phase alignment, mid-bit sampling,
// NRZI decode and bit-stuff removal.
module rx_bit_recover
    import usb_rx_pkg::*;
(
    input logic clk,
    input logic n_rst,
    rx_bit_recover_if.slave bus
);
    localparam logic [CNT_W-1:0]  ROLL_CNT =
        CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_CNT =
        CNT_W'(SAMPLE_POINT);
    localparam logic [ONES_W-1:0] STUFF_CNT =
        ONES_W'(STUFF_LEN);

    logic [CNT_W-1:0]  clk_cnt;
    logic              sample;
    logic              decoded;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic              prev_level_q, prev_level_d;
    logic              shift_q, shift_d;
    logic              rx_bit_q, rx_bit_d;
    logic              stuff_err_q, stuff_err_d;
    logic              byte_pend_q, byte_pend_d;
    logic              byte_q, byte_d;

    flex_counter #(.W(CNT_W)) u_phase (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (bus.d_edge | ~bus.enable),
        .count_enable (bus.enable),
        .rollover_val (ROLL_CNT),
        .count_out    (clk_cnt)
    );

    // An edge landing on the sample point re-aligns instead of sampling.
    assign sample  = bus.enable && (clk_cnt == SAMPLE_CNT)
                     && !bus.d_edge;
    assign decoded = (bus.d_plus_sync == prev_level_q);

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        prev_level_d = prev_level_q;
        shift_d      = 1'b0;
        rx_bit_d     = rx_bit_q;
        stuff_err_d  = 1'b0;
        byte_pend_d  = 1'b0;
        byte_d       = byte_pend_q;
        if (!bus.enable) begin
            bit_cnt_d    = '0;
            ones_cnt_d   = '0;
            prev_level_d = IDLE_LEVEL;
        end else if (sample) begin
            prev_level_d = bus.d_plus_sync;
            if (ones_cnt_q == STUFF_CNT) begin
                ones_cnt_d  = '0;
                stuff_err_d = decoded;
            end else begin
                shift_d     = 1'b1;
                rx_bit_d    = decoded;
                ones_cnt_d  = decoded ?
                              ones_cnt_q + ONES_W'(1) : '0;
                bit_cnt_d   = bit_cnt_q + 3'd1;
                byte_pend_d = (bit_cnt_q == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            prev_level_q <= IDLE_LEVEL;
            shift_q      <= 1'b0;
            rx_bit_q     <= 1'b0;
            stuff_err_q  <= 1'b0;
            byte_pend_q  <= 1'b0;
            byte_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            prev_level_q <= prev_level_d;
            shift_q      <= shift_d;
            rx_bit_q     <= rx_bit_d;
            stuff_err_q  <= stuff_err_d;
            byte_pend_q  <= byte_pend_d;
            byte_q       <= byte_d;
        end
    end

    assign bus.shift_enable  = shift_q;
    assign bus.rx_bit        = rx_bit_q;
    assign bus.stuff_error   = stuff_err_q;
    assign bus.byte_received = byte_q;
endmodule

// File: doc/rx_bit_recover.md
Name: rx_bit_recover

Overview:
- USB full-speed receive bit-recovery stage. It sits directly downstream of the D+ edge detector.
- Consumes the synchronised D+ level and the one-cycle edge pulse. Keeps an oversampled bit-phase counter aligned to incoming transitions, samples each bit mid-period, and NRZI-decodes it.
- Strips stuffed bits and flags stuffing violations.
- Produces shift strobes and decoded bits for the RX shift register, plus a byte-complete pulse for the receiver control unit (RCU).

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period.
- SAMPLE_POINT, 3, phase-counter value at which the line is sampled; must be less than CLKS_PER_BIT-1.
- STUFF_LEN, 6, number of consecutive decoded ones after which a stuffed zero is expected.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- d_plus_sync  in  1  synchronised D+ level.
- d_edge  in  1  one-cycle pulse from the edge detector, asserted the cycle after a D+ transition.
- enable  in  1  RCU receive-window enable; low means idle/clear.
- shift_enable  out  1  one-cycle strobe; rx_bit is valid in the same cycle.
- rx_bit  out  1  NRZI-decoded, unstuffed data bit.
- byte_received  out  1  one-cycle pulse, one cycle after the 8th accepted bit's shift_enable.
- stuff_error  out  1  one-cycle pulse on a bit-stuffing violation.

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk. On reset:
  - all outputs = 0;
  - clk_cnt = 0, bit_cnt = 0, ones_cnt = 0;
  - prev_level = 1 (idle J).
- enable low: clk_cnt, bit_cnt and ones_cnt held at 0; prev_level = 1. shift_enable and stuff_error are forced to 0. A byte_received already launched still completes.
- Phase counter (enable high), in priority order:
  - d_edge: clk_cnt <= 0;
  - else if clk_cnt == CLKS_PER_BIT-1: clk_cnt <= 0;
  - else: clk_cnt <= clk_cnt+1.
- Sample event: enable && clk_cnt == SAMPLE_POINT && !d_edge. When d_edge coincides with the sample point, the edge wins and there is no sample.
- Decode at sample: decoded = (d_plus_sync == prev_level); then prev_level <= d_plus_sync.
- Stuff check at sample when ones_cnt == STUFF_LEN:
  - decoded 0: bit discarded, no shift_enable, ones_cnt <= 0;
  - decoded 1: stuff_error pulses, bit discarded, ones_cnt <= 0.
  - bit_cnt is unchanged in both cases.
- Normal sample (ones_cnt < STUFF_LEN):
  - shift_enable and rx_bit <= decoded;
  - ones_cnt <= decoded ? ones_cnt+1 : 0;
  - bit_cnt <= bit_cnt+1, wrapping 7 -> 0.
  - When the accepted bit is the 8th (bit_cnt was 7), byte_received is set the following cycle.
- Latency:
  - shift_enable, rx_bit and stuff_error are registered and assert the cycle after the sample event.
  - byte_received asserts one cycle after that.
- rx_bit holds its last value between strobes.
- Simultaneous enable fall and sample event: enable low wins, no strobe.
- Counter width: $clog2(CLKS_PER_BIT) for clk_cnt; 3 bits for bit_cnt; $clog2(STUFF_LEN+1) for ones_cnt.

Decomposition:
- Package usb_rx_pkg holds CLKS_PER_BIT, SAMPLE_POINT, STUFF_LEN and IDLE_LEVEL (1'b1) as shared constants. The shift register and RCU use the same package.
- Natural sub-module: flex_counter for the phase counter.
  - clear = d_edge | !enable;
  - count_enable = enable;
  - rollover_val = CLKS_PER_BIT-1.
- Bit/ones counting and NRZI/stuff logic stay inline.

Test Plan:
- Reset: assert n_rst low mid-stream with enable=1 and d_edge pulsing -> all outputs 0 immediately, and first strobe only after a fresh alignment.
- Alignment: enable=1, d_edge at cycle T, d_plus_sync=0 afterwards -> sample at T+4, shift_enable=1 and rx_bit=0 at T+5, then strobes every 8 cycles.
- Sync byte: drive NRZI levels 0,1,0,1,0,1,0,0 (KJKJKJKK), 8 clocks each -> rx_bit sequence 0,0,0,0,0,0,0,1 over 8 strobes, byte_received one cycle after the 8th.
- Stuffed zero: after one decoded 0, hold the level for 6 bit periods, then toggle -> six rx_bit=1 strobes, no strobe for the stuffed bit, and the next bit decodes normally with bit_cnt advanced by 6 only.
- Stuff error: hold the level for 7 bit periods after a transition -> six rx_bit=1 strobes, then stuff_error pulse with no shift_enable, and ones_cnt back to 0.
- Resync and enable drop:
  - d_edge at clk_cnt=5 -> clk_cnt=0 next cycle, next sample 4 cycles after the edge;
  - drop enable after 3 accepted bits, then re-raise -> 8 further bits are needed before byte_received.
